// File: rtl/che_pkg.sv
// Shared defaults and helpers for the CHE line buffer controller.
package che_pkg;

   localparam int DEF_DAT_WD = 9;   // pixel width
   localparam int DEF_LINE_W = 64;  // pixels per line
   localparam int DEF_CNT_WD = 6;   // pixel counter width
   localparam int BUF_NUM    = 2;   // ping-pong bank count

   // Bank select as presented on the 2-bit buffer ports.
   function automatic logic [1:0] bank_num(input logic sel);
      return {1'b0, sel};
   endfunction

endpackage

// File: rtl/che_skid_fifo2.sv
// Two-entry registered FIFO; the head entry drives the output directly so
// there is no combinational path from pop to the data/valid outputs.
module che_skid_fifo2 #(
   parameter int WD = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [WD-1:0] push_dat,
   input  logic          pop,
   output logic [WD-1:0] head_dat,
   output logic          empty,
   output logic [1:0]    cnt
);

   logic [WD-1:0] ent_view [0:1];
   logic          wr_ptr_reg;
   logic          rd_ptr_reg;
   logic [1:0]    cnt_reg;
   logic          do_push;
   logic          do_pop;

   // Qualify push/pop against occupancy; a push into a full FIFO is only
   // allowed when the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop && (cnt_reg != 2'd0);
      do_push = push && ((cnt_reg != 2'd2) || do_pop);
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ent
         logic [WD-1:0] ent_reg;
         // Capture the pushed word into this slot when it is the write target.
         always_ff @(posedge clk) begin
            if (rst) begin
               ent_reg <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
               ent_reg <= push_dat;
            end
         end
         assign ent_view[gi] = ent_reg;
      end
   endgenerate

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         cnt_reg    <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   cnt_reg <= cnt_reg + 2'd1;
            2'b01:   cnt_reg <= cnt_reg - 2'd1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   assign head_dat = ent_view[rd_ptr_reg];
   assign empty    = (cnt_reg == 2'd0);
   assign cnt      = cnt_reg;

endmodule

// File: rtl/che_line_buffer_ctrl.sv
// Ping-pong controller for the two-bank CHE line buffer: fills banks
// alternately from the pixel stream and drains completed banks in order
// through a credit-controlled 2-entry skid FIFO.
module che_line_buffer_ctrl
   import che_pkg::*;
#(
   parameter int DAT_WD = che_pkg::DEF_DAT_WD,
   parameter int LINE_W = che_pkg::DEF_LINE_W,
   parameter int CNT_WD = che_pkg::DEF_CNT_WD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld_i,
   output logic              rdy_o,
   input  logic [DAT_WD-1:0] dat_i,
   output logic              wr_buff_en_o,
   output logic [DAT_WD-1:0] wr_buff_dat_o,
   output logic [1:0]        wr_buff_num_o,
   output logic              rd_buff_en_o,
   output logic [1:0]        rd_buff_num_o,
   input  logic              buff_vld_i,
   input  logic [DAT_WD-1:0] buff_dat_i,
   output logic              vld_o,
   input  logic              rdy_i,
   output logic [DAT_WD-1:0] dat_o,
   output logic              eol_o
);

   localparam logic [CNT_WD-1:0] LAST_PIX = CNT_WD'(LINE_W - 1);

   logic [BUF_NUM-1:0] full_reg;
   logic               wr_sel_reg;
   logic               rd_sel_reg;
   logic [CNT_WD-1:0]  wr_cnt_reg;
   logic [CNT_WD-1:0]  rd_cnt_reg;
   logic               rd_pend_reg;
   logic               rd_eol_reg;

   logic               wr_acc;
   logic               wr_last;
   logic               rd_go;
   logic               rd_last;
   logic               pop;
   logic [2:0]         credit_use;
   logic [2:0]         credit_lim;
   logic [1:0]         skid_cnt;
   logic               skid_empty;
   logic [DAT_WD:0]    skid_head;

   // Handshakes and the read credit check: at most two words may be held in
   // the skid FIFO or in flight from the bank at any time.
   always_comb begin
      wr_acc     = vld_i && !full_reg[wr_sel_reg];
      wr_last    = wr_acc && (wr_cnt_reg == LAST_PIX);
      pop        = !skid_empty && rdy_i;
      credit_use = {1'b0, skid_cnt} + {2'b00, rd_pend_reg};
      credit_lim = 3'd1 + {2'b00, pop};
      rd_go      = full_reg[rd_sel_reg] && (credit_use <= credit_lim);
      rd_last    = rd_go && (rd_cnt_reg == LAST_PIX);
   end

   // Write pointer: pixel count within the line and the bank being filled.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_reg <= '0;
         wr_sel_reg <= 1'b0;
      end else if (wr_acc) begin
         if (wr_last) begin
            wr_cnt_reg <= '0;
            wr_sel_reg <= ~wr_sel_reg;
         end else begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
         end
      end
   end

   // Read pointer plus the one-cycle tags travelling with each bank read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_reg  <= '0;
         rd_sel_reg  <= 1'b0;
         rd_pend_reg <= 1'b0;
         rd_eol_reg  <= 1'b0;
      end else begin
         rd_pend_reg <= rd_go;
         rd_eol_reg  <= rd_last;
         if (rd_go) begin
            if (rd_last) begin
               rd_cnt_reg <= '0;
               rd_sel_reg <= ~rd_sel_reg;
            end else begin
               rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
         end
      end
   end

   // Bank occupancy: set when a line completes, cleared when its last pixel
   // is read. Set and clear never target the same bank in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_reg <= '0;
      end else begin
         if (wr_last) full_reg[wr_sel_reg] <= 1'b1;
         if (rd_last) full_reg[rd_sel_reg] <= 1'b0;
      end
   end

   che_skid_fifo2 #(
      .WD (DAT_WD + 1)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (buff_vld_i),
      .push_dat ({rd_eol_reg, buff_dat_i}),
      .pop      (pop),
      .head_dat (skid_head),
      .empty    (skid_empty),
      .cnt      (skid_cnt)
   );

   assign rdy_o         = !full_reg[wr_sel_reg];
   assign wr_buff_en_o  = wr_acc;
   assign wr_buff_dat_o = dat_i;
   assign wr_buff_num_o = bank_num(wr_sel_reg);
   assign rd_buff_en_o  = rd_go;
   assign rd_buff_num_o = bank_num(rd_sel_reg);
   assign vld_o         = !skid_empty;
   assign dat_o         = skid_head[DAT_WD-1:0];
   assign eol_o         = skid_head[DAT_WD];

endmodule

// File: tb/tb_che_line_buffer_ctrl.sv
// Self-checking bench for che_line_buffer_ctrl with a behavioural 2-bank
// line buffer (1-cycle read latency) and an in-order stream reference.
module tb_che_line_buffer_ctrl;

   localparam int DW = 9;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          vld_i;
   logic          rdy_o;
   logic [DW-1:0] dat_i;
   logic          wr_buff_en_o;
   logic [DW-1:0] wr_buff_dat_o;
   logic [1:0]    wr_buff_num_o;
   logic          rd_buff_en_o;
   logic [1:0]    rd_buff_num_o;
   logic          buff_vld_i;
   logic [DW-1:0] buff_dat_i;
   logic          vld_o;
   logic          rdy_i;
   logic [DW-1:0] dat_o;
   logic          eol_o;

   always #5 clk = ~clk;

   che_line_buffer_ctrl #(
      .DAT_WD (DW),
      .LINE_W (LW),
      .CNT_WD (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .vld_i         (vld_i),
      .rdy_o         (rdy_o),
      .dat_i         (dat_i),
      .wr_buff_en_o  (wr_buff_en_o),
      .wr_buff_dat_o (wr_buff_dat_o),
      .wr_buff_num_o (wr_buff_num_o),
      .rd_buff_en_o  (rd_buff_en_o),
      .rd_buff_num_o (rd_buff_num_o),
      .buff_vld_i    (buff_vld_i),
      .buff_dat_i    (buff_dat_i),
      .vld_o         (vld_o),
      .rdy_i         (rdy_i),
      .dat_o         (dat_o),
      .eol_o         (eol_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [DW-1:0] src_q [$];    // pixels waiting to be offered
   logic [DW:0]   exp_q [$];    // {eol, pixel} expected at the output
   logic [DW-1:0] bank0_q [$];  // line buffer bank contents
   logic [DW-1:0] bank1_q [$];
   int            t_acc [$];
   int            t_pop [$];
   int            pix_in, lines_in, pix_rd, lines_rd, in_flight, cyc;
   bit            lb_pend;
   logic [DW-1:0] lb_dat;
   bit            hold_vld;
   logic [DW-1:0] hold_dat;
   logic          hold_eol;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      src_q.delete(); exp_q.delete(); bank0_q.delete(); bank1_q.delete();
      t_acc.delete(); t_pop.delete();
      pix_in = 0; lines_in = 0; pix_rd = 0; lines_rd = 0; in_flight = 0;
      lb_pend = 0; lb_dat = '0; hold_vld = 0; hold_dat = '0; hold_eol = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; buff_vld_i = 1'b0; buff_dat_i = '0; dat_i = '0;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      #1;
      chk("reset rdy_o", 32'(rdy_o), 1);
      chk("reset vld_o", 32'(vld_o), 0);
      chk("reset dat_o", 32'(dat_o), 0);
      chk("reset eol_o", 32'(eol_o), 0);
      chk("reset wr_en", 32'(wr_buff_en_o), 0);
      chk("reset rd_en", 32'(rd_buff_en_o), 0);
   endtask

   // One clock cycle: drive inputs after negedge, observe just after, and
   // advance the reference according to the handshakes that will complete.
   task automatic step(input bit want_vld, input bit rdy_v);
      bit            exp_rdy;
      logic [DW-1:0] rdat;
      logic [DW:0]   e;
      @(negedge clk);
      buff_vld_i = lb_pend;
      buff_dat_i = lb_pend ? lb_dat : DW'($urandom);
      vld_i      = want_vld && (src_q.size() > 0);
      dat_i      = vld_i ? src_q[0] : DW'($urandom);
      rdy_i      = rdy_v;
      #1;
      cyc++;
      if (hold_vld) begin
         chk("stall vld_o", 32'(vld_o), 1);
         chk("stall dat_o", 32'(dat_o), 32'(hold_dat));
         chk("stall eol_o", 32'(eol_o), 32'(hold_eol));
      end
      exp_rdy = (lines_in - lines_rd) < 2;
      chk("rdy_o", 32'(rdy_o), 32'(exp_rdy));
      chk("wr_en", 32'(wr_buff_en_o), 32'(vld_i && exp_rdy));
      if (wr_buff_en_o) begin
         chk("wr_num", 32'(wr_buff_num_o), 32'(lines_in % 2));
         chk("wr_dat", 32'(wr_buff_dat_o), 32'(dat_i));
         if (wr_buff_num_o[0]) begin
            chk("bank1 overflow", 32'(bank1_q.size() < LW), 1);
            bank1_q.push_back(wr_buff_dat_o);
         end else begin
            chk("bank0 overflow", 32'(bank0_q.size() < LW), 1);
            bank0_q.push_back(wr_buff_dat_o);
         end
         exp_q.push_back({((pix_in % LW) == LW - 1), dat_i});
         if (src_q.size() > 0) void'(src_q.pop_front());
         if ((pix_in % LW) == LW - 1) lines_in++;
         pix_in++;
         t_acc.push_back(cyc);
      end
      lb_pend = 0;
      if (rd_buff_en_o) begin
         chk("rd_num", 32'(rd_buff_num_o), 32'(lines_rd % 2));
         rdat = 'x;
         if (rd_buff_num_o[0]) begin
            chk("bank1 underflow", 32'(bank1_q.size() > 0), 1);
            if (bank1_q.size() > 0) rdat = bank1_q.pop_front();
         end else begin
            chk("bank0 underflow", 32'(bank0_q.size() > 0), 1);
            if (bank0_q.size() > 0) rdat = bank0_q.pop_front();
         end
         lb_pend = 1;
         lb_dat  = rdat;
         if ((pix_rd % LW) == LW - 1) lines_rd++;
         pix_rd++;
         in_flight++;
      end
      if (vld_o && rdy_i) begin
         chk("exp_q nonempty", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dat_o", 32'(dat_o), 32'(e[DW-1:0]));
            chk("eol_o", 32'(eol_o), 32'(e[DW]));
         end
         in_flight--;
         t_pop.push_back(cyc);
      end
      chk("in_flight<=2", 32'(in_flight <= 2), 1);
      hold_vld = vld_o && !rdy_i;
      hold_dat = dat_o;
      hold_eol = eol_o;
   endtask

   // rmode: 0 always ready, 1 toggle 1010, 2 random. vmode: 0 always, 1 random.
   task automatic run_until_done(input int vmode, input int rmode, input int budget, input string tag);
      int n;
      bit r, v;
      n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         case (rmode)
            0:       r = 1'b1;
            1:       r = (n % 2) == 0;
            default: r = $urandom_range(0, 99) < 65;
         endcase
         v = (vmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 70);
         step(v, r);
         n++;
      end
      chk(tag, 32'(src_q.size() + exp_q.size()), 0);
   endtask

   initial begin
      rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; dat_i = '0;
      buff_vld_i = 1'b0; buff_dat_i = '0; cyc = 0;
      clear_model();

      // Test 1: two lines back to back, latency and no bubbles
      do_reset();
      for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
      run_until_done(0, 0, 60, "t1 drained");
      chk("t1 pops", 32'(t_pop.size()), 8);
      if (t_pop.size() == 8 && t_acc.size() == 8) begin
         for (int k = 0; k < 8; k++) chk("t1 out cycle", 32'(t_pop[k]), 32'(t_acc[3] + 3 + k));
      end

      // Test 2: downstream stalled, both banks fill, then release
      do_reset();
      for (int i = 1; i <= 12; i++) src_q.push_back(DW'(i));
      for (int n = 0; n < 20; n++) step(1'b1, 1'b0);
      chk("t2 accepted", 32'(pix_in), 8);
      chk("t2 rdy_o low", 32'(rdy_o), 0);
      run_until_done(0, 0, 100, "t2 drained");

      // Test 3: ready toggling during readout of two lines
      do_reset();
      for (int i = 0; i < 8; i++) src_q.push_back(DW'(100 + i));
      run_until_done(0, 1, 100, "t3 drained");

      // Test 4: reset mid-line discards the partial line
      do_reset();
      for (int i = 11; i <= 14; i++) src_q.push_back(DW'(i));
      for (int n = 0; n < 10 && pix_in < 2; n++) step(1'b1, 1'b1);
      chk("t4 partial", 32'(pix_in), 2);
      do_reset();
      for (int i = 21; i <= 24; i++) src_q.push_back(DW'(i));
      run_until_done(0, 0, 60, "t4 drained");
      chk("t4 count", 32'(t_pop.size()), 4);

      // Test 5: random valid/ready over 100 lines
      do_reset();
      for (int i = 0; i < 100 * LW; i++) src_q.push_back(DW'($urandom));
      run_until_done(1, 2, 5000, "t5 drained");
      chk("t5 lines", 32'(lines_rd), 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
